// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding and width defaults.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  localparam int unsigned ALU_W = 32;

  localparam logic [ALU_W-1:0] DZ_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract divisor, select.
module div_step
  import alu_pkg::*;
#(
  parameter int unsigned N = ALU_W
) (
  input  logic [N:0]   i_rem,
  input  logic [N-1:0] i_quo,
  input  logic [N-1:0] i_div,
  output logic [N:0]   o_rem,
  output logic [N-1:0] o_quo
);

  logic [N:0] w_shift;
  logic [N:0] w_trial;
  logic       w_ge;

  assign w_shift = {i_rem[N-1:0], i_quo[N-1]};
  assign w_trial = w_shift - {1'b0, i_div};
  // A set rem MSB would mean the shifted value exceeds any divisor; it stays clear in practice.
  assign w_ge    = i_rem[N] | ~w_trial[N];

  always_comb begin
    o_rem = w_ge ? w_trial : w_shift;
    o_quo = {i_quo[N-2:0], w_ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, done pulse on completion.
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned N = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         dz
);

  localparam int unsigned CW = $clog2(N) + 1;

  div_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [N:0]   r_rem;
  logic [N-1:0] r_quo;
  logic [N-1:0] r_div;
  logic         r_dz_pend;

  logic [N:0]   w_rem;
  logic [N-1:0] w_quo;

  div_step #(
    .N(N)
  ) u_div_step (
    .i_rem(r_rem),
    .i_quo(r_quo),
    .i_div(r_div),
    .o_rem(w_rem),
    .o_quo(w_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_dz_pend <= 1'b0;
      Q         <= '0;
      R         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      // Divide-by-zero results publish one edge after the start edge; r_quo still holds A here.
      if (r_dz_pend) begin
        r_dz_pend <= 1'b0;
        done      <= 1'b1;
        Q         <= '1;
        R         <= r_quo;
        dz        <= 1'b1;
      end
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_quo <= A;
            r_div <= B;
            r_rem <= '0;
            r_cnt <= '0;
            if (B == '0) begin
              r_state   <= DONE;
              r_dz_pend <= 1'b1;
            end else begin
              r_state <= RUN;
              busy    <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_rem <= w_rem;
          r_quo <= w_quo;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            Q       <= w_quo;
            R       <= w_rem[N-1:0];
            dz      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with a result scoreboard and latency/busy checks.
module tb_seq_divider;
  import alu_pkg::*;

  localparam int unsigned N = ALU_W;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         busy;
  logic         done;
  logic         dz;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   busy_cnt = 0;

  seq_divider #(
    .N(N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .A(a),
    .B(b),
    .Q(q),
    .R(r),
    .busy(busy),
    .done(done),
    .dz(dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (busy) busy_cnt++;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Drives one start cycle at the current time; the result is expected only if the DUT is idle.
  task automatic start_op(input logic [N-1:0] aa, input logic [N-1:0] bb);
    exp_t e;
    if (!busy) begin
      e.q  = (bb == '0) ? DZ_QUO : aa / bb;
      e.r  = (bb == '0) ? aa : aa % bb;
      e.dz = (bb == '0);
      sb.push_back(e);
    end
    start = 1'b1;
    a     = aa;
    b     = bb;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    busy_cnt  = 0;
    a         = $urandom;
    b         = $urandom;
  endtask

  task automatic wait_done(input int exp_lat, input int exp_busy, input string tag);
    exp_t e;
    int   k = 0;
    while (!done && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(64'(done), 64'd1, {tag, " done"});
    chk(64'(cyc - start_cyc), 64'(exp_lat), {tag, " latency"});
    chk(64'(busy_cnt), 64'(exp_busy), {tag, " busy cycles"});
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(64'(q), 64'(e.q), {tag, " Q"});
      chk(64'(r), 64'(e.r), {tag, " R"});
      chk(64'(dz), 64'(e.dz), {tag, " dz"});
    end else begin
      chk(64'(sb.size()), 64'd1, {tag, " scoreboard"});
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    #2 rst_n = 1'b0;
    #1;
    chk(64'(q), 64'd0, "reset Q");
    chk(64'(r), 64'd0, "reset R");
    chk(64'(busy), 64'd0, "reset busy");
    chk(64'(done), 64'd0, "reset done");
    chk(64'(dz), 64'd0, "reset dz");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    start_op(32'd100, 32'd7);
    wait_done(N, N, "100/7");
    idle_cycle();

    start_op(32'hFFFF_FFFF, 32'd1);
    wait_done(N, N, "max/1");
    idle_cycle();

    start_op(32'd5, 32'd9);
    wait_done(N, N, "5/9");

    // Held during the DONE cycle: must be accepted with no idle gap.
    start_op(32'd50, 32'd5);
    chk(64'(done), 64'd0, "b2b done drop");
    chk(64'(busy), 64'd1, "b2b busy");
    wait_done(N, N, "50/5");
    idle_cycle();

    start_op(32'd1234, 32'd0);
    chk(64'(busy), 64'd0, "dz busy");
    wait_done(1, 0, "1234/0");
    idle_cycle();

    start_op(32'd100, 32'd7);
    repeat (9) idle_cycle();
    start_op(32'd8, 32'd2);
    start_cyc = start_cyc - 10;
    busy_cnt  = busy_cnt + 10;
    chk(64'(busy), 64'd1, "ignored start busy");
    wait_done(N, N, "100/7 ign");
    seen = 0;
    repeat (40) begin
      idle_cycle();
      if (done || busy) seen++;
    end
    chk(64'(seen), 64'd0, "ignored start no op");

    start_op(32'd100, 32'd7);
    repeat (15) idle_cycle();
    #1 rst_n = 1'b0;
    #1;
    chk(64'(q), 64'd0, "abort Q");
    chk(64'(r), 64'd0, "abort R");
    chk(64'(busy), 64'd0, "abort busy");
    chk(64'(dz), 64'd0, "abort dz");
    void'(sb.pop_front());
    seen = 0;
    repeat (3) begin
      idle_cycle();
      if (done) seen++;
    end
    chk(64'(seen), 64'd0, "abort no done");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    start_op(32'd9, 32'd4);
    wait_done(N, N, "9/4");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
